// File: rtl/opsg_i2s_tx.sv
// Philips I2S transmitter for the opsg mixer: removes the mid-scale offset and serialises
// left/right words with locally generated bclk/lrclk; sample_tick marks each latch.
module opsg_i2s_tx #(
  parameter int unsigned              BCLK_DIV     = 2,
  parameter int unsigned              SLOT_WIDTH   = 16,
  parameter int unsigned              SAMPLE_WIDTH = 16,
  parameter logic [SAMPLE_WIDTH-1:0]  OFFSET       = SAMPLE_WIDTH'(16'h2000)
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    en,
  input  logic [SAMPLE_WIDTH-1:0] audio_left,
  input  logic [SAMPLE_WIDTH-1:0] audio_right,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    sample_tick
);

  localparam int unsigned FrameBits = 2 * SLOT_WIDTH;
  localparam int unsigned CntW      = (FrameBits > 1) ? $clog2(FrameBits) : 1;
  localparam int unsigned DivW      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [DivW-1:0] DivMax = DivW'(BCLK_DIV - 1);
  localparam logic [CntW-1:0] BitMax = CntW'(FrameBits - 1);
  localparam logic [CntW-1:0] SlotW  = CntW'(SLOT_WIDTH);

  logic [DivW-1:0]         div_cnt_q, div_cnt_d;
  logic [CntW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                    bclk_q, bclk_d;
  logic                    lrclk_q, lrclk_d;
  logic                    sdata_q, sdata_d;
  logic                    tick_q, tick_d;
  logic [SAMPLE_WIDTH-1:0] pcm_l_q, pcm_l_d;
  logic [SAMPLE_WIDTH-1:0] pcm_r_q, pcm_r_d;

  logic                    div_wrap;
  logic                    fall_evt;
  logic [CntW-1:0]         b_next;
  logic [CntW-1:0]         k_idx;

  // Bit `pos` of a left-justified slot; positions past the sample width are padding zeros.
  function automatic logic slot_bit(input logic [SAMPLE_WIDTH-1:0] word,
                                    input logic [CntW-1:0]         pos);
    logic [SAMPLE_WIDTH-1:0] shifted;
    shifted = word << pos;
    return shifted[SAMPLE_WIDTH-1];
  endfunction

  assign div_wrap = (div_cnt_q == DivMax);
  assign fall_evt = en && div_wrap && bclk_q;
  assign b_next   = (bit_cnt_q == BitMax) ? '0 : bit_cnt_q + CntW'(1);
  // One-bclk I2S delay: the bit on the wire lags the slot counter by one position.
  assign k_idx    = (b_next == '0) ? BitMax : b_next - CntW'(1);

  always_comb begin
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    bclk_d    = bclk_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    tick_d    = 1'b0;
    pcm_l_d   = pcm_l_q;
    pcm_r_d   = pcm_r_q;

    if (!en) begin
      div_cnt_d = '0;
      bit_cnt_d = '0;
      bclk_d    = 1'b0;
      lrclk_d   = 1'b0;
      sdata_d   = 1'b0;
    end else begin
      div_cnt_d = div_wrap ? '0 : div_cnt_q + DivW'(1);
      if (div_wrap) begin
        bclk_d = ~bclk_q;
      end
      if (fall_evt) begin
        bit_cnt_d = b_next;
        lrclk_d   = (b_next >= SlotW);
        if (b_next == CntW'(1)) begin
          pcm_l_d = audio_left - OFFSET;
          pcm_r_d = audio_right - OFFSET;
          tick_d  = 1'b1;
        end
        // Uses the freshly latched words so the new left MSB leaves on the latch edge.
        if (k_idx < SlotW) begin
          sdata_d = slot_bit(pcm_l_d, k_idx);
        end else begin
          sdata_d = slot_bit(pcm_r_d, k_idx - SlotW);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
      tick_q    <= 1'b0;
      pcm_l_q   <= '0;
      pcm_r_q   <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      tick_q    <= tick_d;
      pcm_l_q   <= pcm_l_d;
      pcm_r_q   <= pcm_r_d;
    end
  end

  assign bclk        = bclk_q;
  assign lrclk       = lrclk_q;
  assign sdata       = sdata_q;
  assign sample_tick = tick_q;

endmodule

// File: tb/tb_opsg_i2s_tx.sv
// Directed bench for opsg_i2s_tx: clock timing, serial data via a frame receiver, latch
// window, enable/reset behaviour, and a 12-bit sample variant with slot padding.
module tb_opsg_i2s_tx;

  logic        clk;
  logic        n_rst;
  logic        en;
  logic [15:0] audio_left;
  logic [15:0] audio_right;
  logic [11:0] audio_left12;
  logic [11:0] audio_right12;
  logic        bclk, lrclk, sdata, sample_tick;
  logic        bclk12, lrclk12, sdata12, sample_tick12;

  int n_checks;
  int n_errors;

  opsg_i2s_tx #(
    .BCLK_DIV     (2),
    .SLOT_WIDTH   (16),
    .SAMPLE_WIDTH (16),
    .OFFSET       (16'h2000)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .en          (en),
    .audio_left  (audio_left),
    .audio_right (audio_right),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sdata       (sdata),
    .sample_tick (sample_tick)
  );

  opsg_i2s_tx #(
    .BCLK_DIV     (2),
    .SLOT_WIDTH   (16),
    .SAMPLE_WIDTH (12),
    .OFFSET       (12'h800)
  ) dut12 (
    .clk         (clk),
    .n_rst       (n_rst),
    .en          (en),
    .audio_left  (audio_left12),
    .audio_right (audio_right12),
    .bclk        (bclk12),
    .lrclk       (lrclk12),
    .sdata       (sdata12),
    .sample_tick (sample_tick12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Steps until sample_tick is seen; returns number of clocks waited.
  task automatic wait_tick(output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      n++;
      if (sample_tick) return;
    end
    check("tick_timeout", 32'd0, 32'd1);
  endtask

  // Called on the tick sample; receives 32 bits, one per bclk, first bit = left MSB.
  task automatic read_frame(input int chg_k, input logic [15:0] chg_val,
                            output logic [31:0] d, output logic [31:0] d2,
                            output logic [31:0] lr);
    for (int k = 0; k < 32; k++) begin
      d[31-k]  = sdata;
      d2[31-k] = sdata12;
      lr[31-k] = lrclk;
      if (k == chg_k) audio_left = chg_val;
      if (k < 31) repeat (4) step();
    end
  endtask

  initial begin
    logic [31:0] d, d2, lr;
    int ticks;
    int tick_at[3];
    int n;

    n_checks = 0;
    n_errors = 0;
    ticks = 0;
    tick_at = '{0, 0, 0};
    n_rst = 1'b0;
    en = 1'b1;
    audio_left = 16'h2001;
    audio_right = 16'h1FFF;
    audio_left12 = 12'hABC;
    audio_right12 = 12'h7FF;

    // T1: held in reset with en high
    repeat (3) step();
    check("t1_bclk", bclk, 1'b0);
    check("t1_lrclk", lrclk, 1'b0);
    check("t1_sdata", sdata, 1'b0);
    check("t1_tick", sample_tick, 1'b0);

    // T2: clock timing from reset release
    n_rst = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      step();
      if (sample_tick) begin
        if (ticks < 3) tick_at[ticks] = cyc;
        ticks++;
      end
      if (cyc <= 8) check("t2_bclk", bclk, 32'((cyc >> 1) & 1));
      if (cyc == 63 || cyc == 64 || cyc == 127 || cyc == 128 || cyc == 192)
        check("t2_lrclk", lrclk, 32'((cyc / 64) % 2));
    end
    check("t2_tick_count", ticks, 3);
    check("t2_tick0", tick_at[0], 4);
    check("t2_tick1", tick_at[1], 132);
    check("t2_tick2", tick_at[2], 260);

    // T3: data word and lrclk alignment
    wait_tick(n);
    read_frame(-1, 16'h0, d, d2, lr);
    check("t3_left", d[31:16], 16'h0001);
    check("t3_right", d[15:0], 16'hFFFF);
    check("t3_lrclk", lr, 32'h0001_FFFE);
    check("t3_w12_left", d2[31:16], 16'h2BC0);
    check("t3_w12_right", d2[15:0], 16'hFFF0);

    // T4: offset wrap without saturation
    audio_left = 16'h0000;
    audio_right = 16'h2000;
    wait_tick(n);
    check("t4_tick_gap", n, 4);
    read_frame(-1, 16'h0, d, d2, lr);
    check("t4_left", d[31:16], 16'hE000);
    check("t4_right", d[15:0], 16'h0000);

    // T5: input change mid-frame only appears next frame
    audio_left = 16'h3456;
    audio_right = 16'h1FFF;
    wait_tick(n);
    read_frame(8, 16'h2ABC, d, d2, lr);
    check("t5_left_held", d[31:16], 16'h1456);
    check("t5_right", d[15:0], 16'hFFFF);
    wait_tick(n);
    read_frame(-1, 16'h0, d, d2, lr);
    check("t5_left_new", d[31:16], 16'h0ABC);

    // T6: drop en at bit_cnt=20, then re-enable
    wait_tick(n);
    repeat (78) step();
    check("t6_pre_lrclk", lrclk, 1'b1);
    check("t6_pre_bclk", bclk, 1'b1);
    check("t6_pre_sdata", sdata, 1'b1);
    en = 1'b0;
    step();
    check("t6_off_bclk", bclk, 1'b0);
    check("t6_off_lrclk", lrclk, 1'b0);
    check("t6_off_sdata", sdata, 1'b0);
    check("t6_off_tick", sample_tick, 1'b0);
    audio_left = 16'hA5A5;
    audio_right = 16'h1234;
    repeat (10) step();
    check("t6_idle_bclk", bclk, 1'b0);
    check("t6_idle_lrclk", lrclk, 1'b0);
    en = 1'b1;
    wait_tick(n);
    check("t6_first_tick", n, 4);
    read_frame(-1, 16'h0, d, d2, lr);
    check("t6_left", d[31:16], 16'h85A5);
    check("t6_right", d[15:0], 16'hF234);
    check("t6_lrclk", lr, 32'h0001_FFFE);
    check("t6_w12_left", d2[31:16], 16'h2BC0);
    check("t6_w12_right", d2[15:0], 16'hFFF0);

    // Async reset mid-frame, then restart as from power-up
    wait_tick(n);
    repeat (70) step();
    check("rst_pre_lrclk", lrclk, 1'b1);
    check("rst_pre_bclk", bclk, 1'b1);
    check("rst_pre_sdata", sdata, 1'b1);
    #2 n_rst = 1'b0;
    #1;
    check("rst_async_lrclk", lrclk, 1'b0);
    check("rst_async_bclk", bclk, 1'b0);
    check("rst_async_sdata", sdata, 1'b0);
    check("rst_async_tick", sample_tick, 1'b0);
    repeat (3) step();
    check("rst_hold_bclk", bclk, 1'b0);
    n_rst = 1'b1;
    wait_tick(n);
    check("rst_first_tick", n, 4);
    read_frame(-1, 16'h0, d, d2, lr);
    check("rst_left", d[31:16], 16'h85A5);
    check("rst_right", d[15:0], 16'hF234);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
